// File: rtl/calc_pkg.sv
// Shared command, status and glyph definitions for the calculator and its display.
// Seven-segment patterns are {g,f,e,d,c,b,a}, active-low.
package calc_pkg;

   // Command codes carried on the calculator's data output
   localparam logic [3:0] DIG_MAX    = 4'h9;
   localparam logic [3:0] CMD_PLUS   = 4'hA;
   localparam logic [3:0] CMD_MINUS  = 4'hB;
   localparam logic [3:0] CMD_MUL    = 4'hC;
   localparam logic [3:0] CMD_RES    = 4'hD;
   localparam logic [3:0] CMD_NOP    = 4'hE;
   localparam logic [3:0] CMD_CLR    = 4'hF;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   // Calculator status; 2'd3 is treated as an error as well
   localparam logic [1:0] ST_READY = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_ERR   = 2'd2;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_PLUS  = 7'h39;
   localparam logic [6:0] SEG_MUL   = 7'h09;

   function automatic logic [6:0] op_glyph(input logic [3:0] op);
      logic [6:0] g;
      case (op)
         CMD_PLUS:  g = SEG_PLUS;
         CMD_MINUS: g = SEG_DASH;
         CMD_MUL:   g = SEG_MUL;
         default:   g = SEG_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Decimal digit to active-low seven-segment pattern; non-digit codes render blank.
module seg7_decode
   import calc_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/calc_display.sv
// Rebuilds the operand being typed from calculator events and scans it onto an
// 8-digit common-anode display, with error/busy views overriding the digits.
module calc_display
   import calc_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] status,
   input  logic [3:0] data,
   input  logic [2:0] position,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       err_led,
   output logic       busy_led
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

   logic [3:0]    last_data_q;
   logic [2:0]    last_pos_q;
   logic [3:0]    digit_buf_q [8];
   logic [3:0]    digit_buf_d [8];
   logic [3:0]    len_q, len_d;
   logic [3:0]    opg_q, opg_d;
   logic [PW-1:0] pre_q;
   logic [2:0]    slot_q;
   logic          event_hit;

   logic [2:0]    dig_idx;
   logic [3:0]    dig_code;
   logic [6:0]    dig_seg;
   logic [7:0]    an_d;
   logic [6:0]    seg_d;
   logic          err_led_d, busy_led_d;

   // Repeating the same {data,position} pair is deliberately not an event
   assign event_hit = ({data, position} != {last_data_q, last_pos_q});

   always_comb begin
      digit_buf_d = digit_buf_q;
      len_d       = len_q;
      opg_d       = opg_q;
      if (event_hit) begin
         case (data)
            CMD_PLUS, CMD_MINUS, CMD_MUL: begin
               for (int i = 0; i < 8; i++) digit_buf_d[i] = CODE_BLANK;
               len_d = 4'd0;
               opg_d = data;
            end
            CMD_CLR: begin
               for (int i = 0; i < 8; i++) digit_buf_d[i] = CODE_BLANK;
               len_d = 4'd0;
               opg_d = 4'd0;
            end
            CMD_RES, CMD_NOP: ;
            default: begin
               if (data <= DIG_MAX) begin
                  digit_buf_d[position] = data;
                  len_d                 = {1'b0, position} + 4'd1;
                  opg_d                 = 4'd0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_data_q <= CMD_CLR;
         last_pos_q  <= 3'd0;
         len_q       <= 4'd0;
         opg_q       <= 4'd0;
         for (int i = 0; i < 8; i++) digit_buf_q[i] <= CODE_BLANK;
      end else begin
         last_data_q <= data;
         last_pos_q  <= position;
         len_q       <= len_d;
         opg_q       <= opg_d;
         for (int i = 0; i < 8; i++) digit_buf_q[i] <= digit_buf_d[i];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre_q  <= '0;
         slot_q <= 3'd0;
      end else if (pre_q == PRE_MAX) begin
         pre_q  <= '0;
         slot_q <= slot_q + 3'd1;
      end else begin
         pre_q  <= pre_q + 1'b1;
      end
   end

   // Oldest digit sits leftmost; len of 8 wraps to index 7-slot via 3-bit math
   always_comb begin
      dig_idx  = len_q[2:0] - 3'd1 - slot_q;
      dig_code = digit_buf_q[dig_idx];
   end

   seg7_decode u_seg7_decode (
      .code (dig_code),
      .seg  (dig_seg)
   );

   always_comb begin
      an_d       = ~(8'd1 << slot_q);
      seg_d      = SEG_BLANK;
      err_led_d  = (status >= ST_ERR);
      busy_led_d = (status == ST_BUSY);
      case (status)
         ST_READY: begin
            if (len_q != 4'd0) begin
               if ({1'b0, slot_q} < len_q) seg_d = dig_seg;
            end else if (slot_q == 3'd0) begin
               seg_d = op_glyph(opg_q);
            end
         end
         ST_BUSY: seg_d = SEG_DASH;
         default: begin
            case (slot_q)
               3'd2:       seg_d = SEG_E;
               3'd1, 3'd0: seg_d = SEG_R;
               default:    seg_d = SEG_BLANK;
            endcase
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         an       <= 8'hFF;
         seg      <= SEG_BLANK;
         err_led  <= 1'b0;
         busy_led <= 1'b0;
      end else begin
         an       <= an_d;
         seg      <= seg_d;
         err_led  <= err_led_d;
         busy_led <= busy_led_d;
      end
   end

endmodule
